signal_period_meter: RTL and testbench

Measures the waveform produced by the signal generator at the far end of its sample stream. It accepts the same 16-bit unsigned sample words, each qualified by a one-cycle strobe, that are driven towards the DAC on GPIO. For each full waveform period it reports:
- the period length in clock cycles
- the sample count in the period
- the minimum and maximum sample in the period

The block sits beside the generator in the top level. Its outputs feed HEX/LED display logic and the self-checking bench, which uses them to confirm faster/slower frequency steps.

---
 rtl/signal_period_meter.sv | 155 +++++++++++++++
 tb/tb_signal_period_meter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/signal_period_meter.sv
// Measures period, sample count and min/max of a sample stream between
// consecutive rising crossings of a hysteresis band around midscale.
module signal_period_meter #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 32,
  parameter int HYST   = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid_i,
  input  logic [DATA_W-1:0] sample_i,
  output logic              period_valid_o,
  output logic [CNT_W-1:0]  period_clks_o,
  output logic [CNT_W-1:0]  period_samples_o,
  output logic [DATA_W-1:0] min_o,
  output logic [DATA_W-1:0] max_o,
  output logic              locked_o,
  output logic              overflow_o,
  output logic [1:0]        state_o
);

  localparam logic [1:0] ST_SEEK = 2'd0;
  localparam logic [1:0] ST_LOW  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;

  // Thresholds carry one extra bit so MID +/- HYST can never wrap.
  localparam logic [DATA_W:0] MID  = (DATA_W+1)'(1) << (DATA_W-1);
  localparam logic [DATA_W:0] LO_T = MID - (DATA_W+1)'(HYST);
  localparam logic [DATA_W:0] HI_T = MID + (DATA_W+1)'(HYST);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]        state_q, state_d;
  logic              first_seen_q, first_seen_d;
  logic [CNT_W-1:0]  clk_cnt_q, clk_cnt_d;
  logic [CNT_W-1:0]  smp_cnt_q, smp_cnt_d;
  logic [DATA_W-1:0] min_acc_q, min_acc_d;
  logic [DATA_W-1:0] max_acc_q, max_acc_d;
  logic              period_valid_q, period_valid_d;
  logic [CNT_W-1:0]  period_clks_q, period_clks_d;
  logic [CNT_W-1:0]  period_samples_q, period_samples_d;
  logic [DATA_W-1:0] min_q, min_d;
  logic [DATA_W-1:0] max_q, max_d;
  logic              locked_q, locked_d;
  logic              overflow_q, overflow_d;

  logic [DATA_W:0] samp_ext;
  logic            is_lo, is_hi, crossing, ovf_evt;

  always_comb begin
    samp_ext = {1'b0, sample_i};
    is_lo    = samp_ext <= LO_T;
    is_hi    = samp_ext >= HI_T;
    crossing = sample_valid_i && (state_q == ST_LOW) && is_hi;
    // Only a running measurement can overflow; once cleared it cannot re-fire.
    ovf_evt  = first_seen_q && (clk_cnt_q == CNT_MAX) && !crossing;

    state_d = state_q;
    if (sample_valid_i) begin
      case (state_q)
        ST_SEEK: begin
          if (is_lo)      state_d = ST_LOW;
          else if (is_hi) state_d = ST_HIGH;
        end
        ST_LOW:  if (is_hi) state_d = ST_HIGH;
        ST_HIGH: if (is_lo) state_d = ST_LOW;
        default: state_d = ST_SEEK;
      endcase
    end

    first_seen_d     = first_seen_q;
    clk_cnt_d        = clk_cnt_q;
    smp_cnt_d        = smp_cnt_q;
    min_acc_d        = min_acc_q;
    max_acc_d        = max_acc_q;
    period_valid_d   = 1'b0;
    period_clks_d    = period_clks_q;
    period_samples_d = period_samples_q;
    min_d            = min_q;
    max_d            = max_q;
    locked_d         = locked_q;
    overflow_d       = overflow_q;

    if (crossing) begin
      if (first_seen_q) begin
        period_valid_d   = 1'b1;
        period_clks_d    = clk_cnt_q;
        period_samples_d = smp_cnt_q;
        min_d            = min_acc_q;
        max_d            = max_acc_q;
        locked_d         = 1'b1;
        overflow_d       = 1'b0;
      end
      first_seen_d = 1'b1;
      clk_cnt_d    = CNT_ONE;
      smp_cnt_d    = CNT_ONE;
      min_acc_d    = sample_i;
      max_acc_d    = sample_i;
    end else if (ovf_evt) begin
      overflow_d   = 1'b1;
      locked_d     = 1'b0;
      first_seen_d = 1'b0;
      state_d      = ST_SEEK;
    end else if (first_seen_q) begin
      clk_cnt_d = clk_cnt_q + CNT_ONE;
      if (sample_valid_i) begin
        smp_cnt_d = smp_cnt_q + CNT_ONE;
        if (sample_i < min_acc_q) min_acc_d = sample_i;
        if (sample_i > max_acc_q) max_acc_d = sample_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_SEEK;
      first_seen_q     <= 1'b0;
      clk_cnt_q        <= '0;
      smp_cnt_q        <= '0;
      min_acc_q        <= '0;
      max_acc_q        <= '0;
      period_valid_q   <= 1'b0;
      period_clks_q    <= '0;
      period_samples_q <= '0;
      min_q            <= '0;
      max_q            <= '0;
      locked_q         <= 1'b0;
      overflow_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      first_seen_q     <= first_seen_d;
      clk_cnt_q        <= clk_cnt_d;
      smp_cnt_q        <= smp_cnt_d;
      min_acc_q        <= min_acc_d;
      max_acc_q        <= max_acc_d;
      period_valid_q   <= period_valid_d;
      period_clks_q    <= period_clks_d;
      period_samples_q <= period_samples_d;
      min_q            <= min_d;
      max_q            <= max_d;
      locked_q         <= locked_d;
      overflow_q       <= overflow_d;
    end
  end

  assign period_valid_o   = period_valid_q;
  assign period_clks_o    = period_clks_q;
  assign period_samples_o = period_samples_q;
  assign min_o            = min_q;
  assign max_o            = max_q;
  assign locked_o         = locked_q;
  assign overflow_o       = overflow_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_signal_period_meter.sv
// Directed bench for signal_period_meter with a 12-bit cycle counter so the
// saturation path is reachable in a short run.
module tb_signal_period_meter;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 12;

  logic              clk;
  logic              rst;
  logic              sample_valid_i;
  logic [DATA_W-1:0] sample_i;
  logic              period_valid_o;
  logic [CNT_W-1:0]  period_clks_o;
  logic [CNT_W-1:0]  period_samples_o;
  logic [DATA_W-1:0] min_o;
  logic [DATA_W-1:0] max_o;
  logic              locked_o;
  logic              overflow_o;
  logic [1:0]        state_o;

  signal_period_meter #(.DATA_W(DATA_W), .CNT_W(CNT_W), .HYST(256)) dut (
    .clk              (clk),
    .rst              (rst),
    .sample_valid_i   (sample_valid_i),
    .sample_i         (sample_i),
    .period_valid_o   (period_valid_o),
    .period_clks_o    (period_clks_o),
    .period_samples_o (period_samples_o),
    .min_o            (min_o),
    .max_o            (max_o),
    .locked_o         (locked_o),
    .overflow_o       (overflow_o),
    .state_o          (state_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int last_stamp = 0;
  int prev_stamp = 0;
  int p0 = 0;
  logic [CNT_W-1:0]  last_clks;
  logic [CNT_W-1:0]  last_smps;
  logic [DATA_W-1:0] last_min;
  logic [DATA_W-1:0] last_max;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one clock with the given inputs; outputs are sampled 1ns after the edge.
  task automatic send(input logic v, input logic [DATA_W-1:0] s);
    sample_valid_i = v;
    sample_i       = s;
    @(posedge clk);
    #1;
    cyc++;
    if (period_valid_o) begin
      pulse_cnt++;
      prev_stamp = last_stamp;
      last_stamp = cyc;
      last_clks  = period_clks_o;
      last_smps  = period_samples_o;
      last_min   = min_o;
      last_max   = max_o;
    end
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    sample_valid_i = 1'b0;
    sample_i       = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // 512 low samples then 512 high samples, one valid every gap clocks.
  task automatic square_period(input int gap);
    for (int i = 0; i < 512; i++) begin
      send(1'b1, 16'h1000);
      if (gap == 2) send(1'b0, 16'h1000);
    end
    for (int i = 0; i < 512; i++) begin
      send(1'b1, 16'hF000);
      if (gap == 2) send(1'b0, 16'hF000);
    end
  endtask

  initial begin
    rst            = 1'b1;
    sample_valid_i = 1'b0;
    sample_i       = '0;
    #12;
    check("rst_valid",    period_valid_o,   0);
    check("rst_clks",     period_clks_o,    0);
    check("rst_smps",     period_samples_o, 0);
    check("rst_min",      min_o,            0);
    check("rst_max",      max_o,            0);
    check("rst_locked",   locked_o,         0);
    check("rst_overflow", overflow_o,       0);
    check("rst_state",    state_o,          0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Back-to-back crossings: every other sample is a rising crossing.
    send(1'b1, 16'h0000);
    send(1'b1, 16'hFFFF);
    check("b2b_no_first_pulse", pulse_cnt, 0);
    send(1'b1, 16'h0000);
    send(1'b1, 16'hFFFF);
    check("b2b_valid",  period_valid_o,   1);
    check("b2b_clks",   period_clks_o,    2);
    check("b2b_smps",   period_samples_o, 2);
    check("b2b_min",    min_o,            16'h0000);
    check("b2b_max",    max_o,            16'hFFFF);
    check("b2b_locked", locked_o,         1);
    send(1'b1, 16'h0000);
    check("b2b_pulse_width", period_valid_o, 0);
    send(1'b1, 16'hFFFF);
    check("b2b_second_valid", period_valid_o, 1);
    check("b2b_spacing", last_stamp - prev_stamp, 2);

    // Overflow: lock exists, then the signal sticks high.
    for (int k = 0; k < 4094; k++) send(1'b1, 16'hFFFF);
    check("ovf_not_yet",    overflow_o, 0);
    check("ovf_locked_pre", locked_o,   1);
    send(1'b1, 16'hFFFF);
    check("ovf_set",        overflow_o, 1);
    check("ovf_unlocked",   locked_o,   0);
    check("ovf_state_seek", state_o,    0);
    check("ovf_hold_clks",  period_clks_o, 2);
    p0 = pulse_cnt;
    send(1'b1, 16'h1000);
    send(1'b1, 16'hF000);
    check("ovf_restart_no_pulse", pulse_cnt - p0, 0);
    check("ovf_still_set",        overflow_o,     1);
    for (int k = 0; k < 999; k++) send(1'b1, 16'h1000);
    send(1'b1, 16'hF000);
    check("ovf_report_valid", period_valid_o,   1);
    check("ovf_report_clks",  period_clks_o,    1000);
    check("ovf_report_smps",  period_samples_o, 1000);
    check("ovf_cleared",      overflow_o,       0);
    check("ovf_relocked",     locked_o,         1);

    // Square wave at one sample every 2 clocks, then a frequency step.
    do_reset();
    p0 = pulse_cnt;
    square_period(2);
    square_period(2);
    square_period(2);
    check("sq_pulses",  pulse_cnt - p0, 2);
    check("sq_clks",    last_clks,      2048);
    check("sq_smps",    last_smps,      1024);
    check("sq_min",     last_min,       16'h1000);
    check("sq_max",     last_max,       16'hF000);
    check("sq_locked",  locked_o,       1);
    check("sq_spacing", last_stamp - prev_stamp, 2048);
    square_period(1);
    check("step_mid_clks", last_clks, 1536);
    check("step_mid_smps", last_smps, 1024);
    square_period(1);
    check("step_clks", last_clks, 1024);
    check("step_smps", last_smps, 1024);

    // Hysteresis: samples stay inside the dead band.
    do_reset();
    p0 = pulse_cnt;
    for (int k = 0; k < 5000; k++) begin
      send(1'b1, 16'h8000 + 16'd200);
      send(1'b1, 16'h8000 - 16'd200);
    end
    check("hyst_no_pulse", pulse_cnt - p0, 0);
    check("hyst_state",    state_o,        0);
    check("hyst_locked",   locked_o,       0);

    // Reset mid-period.
    do_reset();
    square_period(2);
    square_period(2);
    check("mid_locked_pre", locked_o, 1);
    for (int k = 0; k < 256; k++) begin
      send(1'b1, 16'h1000);
      send(1'b0, 16'h1000);
    end
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_clks",   period_clks_o,    0);
    check("mid_rst_smps",   period_samples_o, 0);
    check("mid_rst_locked", locked_o,         0);
    check("mid_rst_max",    max_o,            0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    p0 = pulse_cnt;
    square_period(2);
    check("mid_one_crossing_no_pulse", pulse_cnt - p0, 0);
    square_period(2);
    check("mid_first_pulse", pulse_cnt - p0, 1);
    check("mid_clks",        last_clks,      2048);
    check("mid_smps",        last_smps,      1024);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
